seg_display_arbiter: RTL and testbench



---
 rtl/seg_pkg.sv | 33 +++
 rtl/seg_glyph_decoder.sv | 32 +++
 rtl/seg_display_arbiter.sv | 163 ++++++++++++++++
 tb/tb_seg_display_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment display blocks.
// Holds the glyph patterns, the arbiter state encoding and a small
// constant helper used to size counters.
package seg_pkg;

  localparam logic [7:0] SEG_DASH  = 8'h02;
  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_FULL  = 8'hFF;

  // Digit patterns 0..9
  localparam logic [7:0] SEG_D0 = 8'hFD;
  localparam logic [7:0] SEG_D1 = 8'hC1;
  localparam logic [7:0] SEG_D2 = 8'h6F;
  localparam logic [7:0] SEG_D3 = 8'hE7;
  localparam logic [7:0] SEG_D4 = 8'hD3;
  localparam logic [7:0] SEG_D5 = 8'hB7;
  localparam logic [7:0] SEG_D6 = 8'hBF;
  localparam logic [7:0] SEG_D7 = 8'hE1;
  localparam logic [7:0] SEG_D8 = 8'hFF;
  localparam logic [7:0] SEG_D9 = 8'hF7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SHOW = 2'b01,
    ST_GAP  = 2'b10
  } state_e;

  // Larger of two integers, for sizing counters at elaboration time.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seg_glyph_decoder.sv
// Combinational 4-bit glyph code to 8-bit segment pattern decoder.
// Ports:
//   code - glyph code (0..9 digits, 10 dash, 11 full '8.', 12..15 blank)
//   seg  - segment pattern
module seg_glyph_decoder
  import seg_pkg::*;
(
  input  logic [3:0] code,
  output logic [7:0] seg
);

  // Table lookup of the glyph pattern.
  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'd0:    seg = SEG_D0;
      4'd1:    seg = SEG_D1;
      4'd2:    seg = SEG_D2;
      4'd3:    seg = SEG_D3;
      4'd4:    seg = SEG_D4;
      4'd5:    seg = SEG_D5;
      4'd6:    seg = SEG_D6;
      4'd7:    seg = SEG_D7;
      4'd8:    seg = SEG_D8;
      4'd9:    seg = SEG_D9;
      4'd10:   seg = SEG_DASH;
      4'd11:   seg = SEG_FULL;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter sharing one 7-segment output between NREQ requesters.
// The winner's glyph is shown for DWELL cycles, then GAP blank cycles,
// then the display returns to the idle dash.
// Ports:
//   clk, rst_n - clock, synchronous active-low reset
//   ena        - global enable; low freezes all state and outputs
//   req        - per-requester level request
//   code       - 4-bit glyph code of requester i at [4i+3:4i]
//   grant      - one-hot current owner (zero when unowned)
//   done       - pulse on the final dwell cycle
//   busy       - high while showing or in the gap
//   seg        - registered segment pattern
module seg_display_arbiter
  import seg_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DWELL = 8,
  parameter int GAP   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] code,
  output logic [NREQ-1:0]   grant,
  output logic              done,
  output logic              busy,
  output logic [7:0]        seg
);

  localparam int CW = $clog2(max_int(DWELL, GAP) + 1);
  localparam int PW = $clog2(NREQ);

  localparam logic [CW-1:0] DWELL_C  = CW'(DWELL);
  localparam logic [CW-1:0] GAP_C    = CW'(GAP);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);
  localparam logic [PW:0]   NREQ_W   = (PW + 1)'(NREQ);

  state_e            state_r;
  logic [PW-1:0]     ptr_r;
  logic [CW-1:0]     dwell_r;
  logic [CW-1:0]     gap_r;
  logic [NREQ-1:0]   grant_r;
  logic              done_r;
  logic              busy_r;
  logic [7:0]        seg_r;

  logic              win_found_s;
  logic [PW-1:0]     win_idx_s;
  logic [NREQ-1:0]   win_onehot_s;
  logic [PW-1:0]     ptr_next_s;
  logic [3:0]        win_code_s;
  logic [7:0]        win_glyph_s;

  // Round-robin scan starting at ptr_r; first asserted request wins.
  always_comb begin
    logic [PW:0] pos_v;
    win_found_s = 1'b0;
    win_idx_s   = {PW{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      pos_v = {1'b0, ptr_r} + (PW + 1)'(i);
      pos_v = (pos_v >= NREQ_W) ? (pos_v - NREQ_W) : pos_v;
      if (!win_found_s && req[pos_v[PW-1:0]]) begin
        win_found_s = 1'b1;
        win_idx_s   = pos_v[PW-1:0];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  assign win_onehot_s = {{(NREQ-1){1'b0}}, 1'b1} << win_idx_s;
  assign ptr_next_s   = (win_idx_s == LAST_IDX) ? {PW{1'b0}} : (win_idx_s + PW'(1));
  assign win_code_s   = code[{win_idx_s, 2'b00} +: 4];

  // The glyph is decoded once at grant time and the pattern register holds
  // it through the dwell, so later code changes cannot reach the display.
  seg_glyph_decoder u_decoder (
    .code (win_code_s),
    .seg  (win_glyph_s)
  );

  // Arbitration FSM with registered outputs; ena low freezes everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      ptr_r   <= {PW{1'b0}};
      dwell_r <= {CW{1'b0}};
      gap_r   <= {CW{1'b0}};
      grant_r <= {NREQ{1'b0}};
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
      seg_r   <= SEG_DASH;
    end else if (ena) begin
      case (state_r)
        ST_IDLE: begin
          if (win_found_s) begin
            state_r <= ST_SHOW;
            grant_r <= win_onehot_s;
            seg_r   <= win_glyph_s;
            ptr_r   <= ptr_next_s;
            dwell_r <= CNT_ONE;
            busy_r  <= 1'b1;
            done_r  <= (DWELL_C == CNT_ONE);
          end else begin
            grant_r <= {NREQ{1'b0}};
            seg_r   <= SEG_DASH;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
          end
        end
        ST_SHOW: begin
          if (dwell_r == DWELL_C) begin
            dwell_r <= {CW{1'b0}};
            grant_r <= {NREQ{1'b0}};
            done_r  <= 1'b0;
            if (GAP > 0) begin
              state_r <= ST_GAP;
              gap_r   <= CNT_ONE;
              seg_r   <= SEG_BLANK;
              busy_r  <= 1'b1;
            end else begin
              state_r <= ST_IDLE;
              seg_r   <= SEG_DASH;
              busy_r  <= 1'b0;
            end
          end else begin
            // done is registered, so it is raised on the edge that loads
            // the final count.
            dwell_r <= dwell_r + CNT_ONE;
            done_r  <= ((dwell_r + CNT_ONE) == DWELL_C);
          end
        end
        ST_GAP: begin
          if (gap_r == GAP_C) begin
            state_r <= ST_IDLE;
            gap_r   <= {CW{1'b0}};
            seg_r   <= SEG_DASH;
            busy_r  <= 1'b0;
          end else begin
            gap_r   <= gap_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          dwell_r <= {CW{1'b0}};
          gap_r   <= {CW{1'b0}};
          grant_r <= {NREQ{1'b0}};
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          seg_r   <= SEG_DASH;
        end
      endcase
    end
  end

  assign grant = grant_r;
  assign done  = done_r;
  assign busy  = busy_r;
  assign seg   = seg_r;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Scoreboard bench for seg_display_arbiter: one instance with the default
// DWELL=8/GAP=1 and one with DWELL=3/GAP=0. Each stimulus step pushes the
// expected outputs of both instances; a monitor pops and compares every cycle.
module tb_seg_display_arbiter;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic [3:0]  req_a;
  logic [3:0]  req_b;
  logic [15:0] code;

  logic [3:0]  grant_a, grant_b;
  logic        done_a, done_b, busy_a, busy_b;
  logic [7:0]  seg_a, seg_b;

  seg_display_arbiter #(.NREQ(4), .DWELL(8), .GAP(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .req(req_a), .code(code),
    .grant(grant_a), .done(done_a), .busy(busy_a), .seg(seg_a)
  );

  seg_display_arbiter #(.NREQ(4), .DWELL(3), .GAP(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .req(req_b), .code(code),
    .grant(grant_b), .done(done_b), .busy(busy_b), .seg(seg_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pending stimulus values applied by the next tick.
  logic        rstn_v;
  logic        ena_v;
  logic [3:0]  req_a_v;
  logic [3:0]  req_b_v;
  logic [15:0] code_v;

  logic [13:0] qa[$];
  logic [13:0] qb[$];
  logic [13:0] ea, eb;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int step_a   = 0;
  int step_b   = 0;

  function automatic logic [13:0] ex(input logic [7:0] s, input logic [3:0] g,
                                     input logic d, input logic b);
    return {s, g, d, b};
  endfunction

  localparam logic [13:0] IDLE_E = {8'h02, 4'h0, 1'b0, 1'b0};
  localparam logic [13:0] GAP_E  = {8'h00, 4'h0, 1'b0, 1'b1};

  // One clock edge: apply pending inputs and enqueue the outputs expected after it.
  task automatic tick(input logic [13:0] exp_a, input logic [13:0] exp_b);
    @(negedge clk);
    rst_n = rstn_v;
    ena   = ena_v;
    req_a = req_a_v;
    req_b = req_b_v;
    code  = code_v;
    qa.push_back(exp_a);
    qb.push_back(exp_b);
  endtask

  // Dwell counts from..to of instance A showing pattern s with grant g.
  task automatic show_a(input logic [7:0] s, input logic [3:0] g, input int from, input int to);
    for (int k = from; k <= to; k++) tick(ex(s, g, (k == 8), 1'b1), IDLE_E);
  endtask

  // Monitor: compare both instances against the scoreboard every cycle.
  always @(posedge clk) begin
    #1;
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      chk_cnt++;
      step_a++;
      if ({seg_a, grant_a, done_a, busy_a} === ea) pass_cnt++;
      else $display("FAIL dut_a step %0d: got seg=%h grant=%b done=%b busy=%b, expected seg=%h grant=%b done=%b busy=%b",
                    step_a, seg_a, grant_a, done_a, busy_a, ea[13:6], ea[5:2], ea[1], ea[0]);
    end
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      chk_cnt++;
      step_b++;
      if ({seg_b, grant_b, done_b, busy_b} === eb) pass_cnt++;
      else $display("FAIL dut_b step %0d: got seg=%h grant=%b done=%b busy=%b, expected seg=%h grant=%b done=%b busy=%b",
                    step_b, seg_b, grant_b, done_b, busy_b, eb[13:6], eb[5:2], eb[1], eb[0]);
    end
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

  logic [7:0] rr_seg [4];
  logic [3:0] g_v;

  initial begin
    rr_seg[0] = 8'hC1; rr_seg[1] = 8'h6F; rr_seg[2] = 8'hE7; rr_seg[3] = 8'hD3;
    rst_n = 1'b0; ena = 1'b1; req_a = 4'h0; req_b = 4'h0; code = 16'h0000;
    rstn_v = 1'b0; ena_v = 1'b1; req_a_v = 4'h0; req_b_v = 4'h0; code_v = 16'h0000;

    // Reset for two cycles, then idle with no requests.
    tick(IDLE_E, IDLE_E);
    tick(IDLE_E, IDLE_E);
    rstn_v = 1'b1;
    repeat (3) tick(IDLE_E, IDLE_E);

    // Single lone requester, code 7; re-granted after gap and one idle cycle.
    req_a_v = 4'b0001; code_v = 16'h0007;
    show_a(8'hE1, 4'b0001, 1, 8);
    tick(GAP_E, IDLE_E);
    tick(IDLE_E, IDLE_E);
    show_a(8'hE1, 4'b0001, 1, 1);
    req_a_v = 4'b0000;
    show_a(8'hE1, 4'b0001, 2, 8);
    tick(GAP_E, IDLE_E);
    tick(IDLE_E, IDLE_E);
    tick(IDLE_E, IDLE_E);

    // Round robin from a freshly reset pointer, codes 1,2,3,4.
    rstn_v = 1'b0;
    tick(IDLE_E, IDLE_E);
    rstn_v = 1'b1;
    req_a_v = 4'b1111; code_v = 16'h4321;
    for (int k = 0; k < 5; k++) begin
      g_v = 4'b0001 << (k % 4);
      show_a(rr_seg[k % 4], g_v, 1, 8);
      tick(GAP_E, IDLE_E);
      tick(IDLE_E, IDLE_E);
    end
    req_a_v = 4'b0000;
    tick(IDLE_E, IDLE_E);

    // Latching: requester 2 drops req and changes code 5 -> 9 after grant.
    req_a_v = 4'b0100; code_v = 16'h0500;
    show_a(8'hB7, 4'b0100, 1, 1);
    req_a_v = 4'b0000; code_v = 16'h0900;
    show_a(8'hB7, 4'b0100, 2, 8);
    tick(GAP_E, IDLE_E);
    tick(IDLE_E, IDLE_E);

    // ena freeze for 5 cycles at dwell count 3 (pointer at 3 wraps to 0).
    req_a_v = 4'b0001; code_v = 16'h0000;
    show_a(8'hFD, 4'b0001, 1, 3);
    ena_v = 1'b0;
    repeat (5) tick(ex(8'hFD, 4'b0001, 1'b0, 1'b1), IDLE_E);
    ena_v = 1'b1; req_a_v = 4'b0000;
    show_a(8'hFD, 4'b0001, 4, 8);
    tick(GAP_E, IDLE_E);
    tick(IDLE_E, IDLE_E);
    // ena low in idle ignores a pending request.
    ena_v = 1'b0; req_a_v = 4'b0010;
    repeat (2) tick(IDLE_E, IDLE_E);
    ena_v = 1'b1; req_a_v = 4'b0000;
    tick(IDLE_E, IDLE_E);

    // Reset at dwell count 4 aborts without done; pointer returns to 0.
    req_a_v = 4'b0010; code_v = 16'h0080;
    show_a(8'hFF, 4'b0010, 1, 4);
    rstn_v = 1'b0; req_a_v = 4'b0000;
    tick(IDLE_E, IDLE_E);
    rstn_v = 1'b1;
    tick(IDLE_E, IDLE_E);
    req_a_v = 4'b1010;
    show_a(8'hFF, 4'b0010, 1, 1);
    rstn_v = 1'b0; req_a_v = 4'b0000;
    tick(IDLE_E, IDLE_E);
    rstn_v = 1'b1;
    tick(IDLE_E, IDLE_E);

    // GAP=0 instance (DWELL=3): SHOW goes straight to IDLE, period 4.
    req_b_v = 4'b0001; code_v = 16'h0003;
    for (int k = 1; k <= 3; k++) tick(IDLE_E, ex(8'hE7, 4'b0001, (k == 3), 1'b1));
    tick(IDLE_E, IDLE_E);
    tick(IDLE_E, ex(8'hE7, 4'b0001, 1'b0, 1'b1));
    req_b_v = 4'b0000;
    for (int k = 2; k <= 3; k++) tick(IDLE_E, ex(8'hE7, 4'b0001, (k == 3), 1'b1));
    tick(IDLE_E, IDLE_E);
    tick(IDLE_E, IDLE_E);

    // Drain the scoreboard; anything left over is a missed comparison.
    @(negedge clk);
    @(negedge clk);
    chk_cnt++;
    if (qa.size() == 0 && qb.size() == 0) pass_cnt++;
    else $display("FAIL drain: %0d/%0d entries left, expected 0/0", qa.size(), qb.size());

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
